reflet_bus_arbiter: RTL

- Shares one synchronous single-port memory bus between the reflet_cpu (master 0) and a secondary DMA-style master (master 1).
- Stalls the CPU through its `enable` input while the secondary master owns the bus.
- Guarantees the CPU sees correct read data when it resumes.
- Bounds each secondary-master tenure so the CPU cannot be starved.
- Sits between the CPU and the ROM/RAM address decoder in the SoC top.

---
 rtl/reflet_bus_arbiter_pkg.sv | 19 +
 rtl/reflet_bus_arbiter_if.sv | 41 ++++
 rtl/reflet_bus_arbiter_counter.sv | 38 +++
 rtl/reflet_bus_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared types and helpers for the reflet bus arbiter.
package reflet_bus_arbiter_pkg;

   localparam int unsigned WordsizeDefault = 16;

   // Bus ownership phases; encoding is visible on debug probes, keep it fixed.
   typedef enum logic [1:0] {
      StCpuOwn   = 2'd0,
      StHandover = 2'd1,
      StDmaOwn   = 2'd2,
      StHandback = 2'd3
   } arb_state_e;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/reflet_bus_arbiter_if.sv
// CPU, secondary-master and memory signals around the bus arbiter.
interface reflet_bus_arbiter_if
   import reflet_bus_arbiter_pkg::*;
#(
   parameter int unsigned Wordsize = WordsizeDefault
);
   logic                enable;
   logic                cpu_enable;
   logic [Wordsize-1:0] cpu_addr;
   logic [Wordsize-1:0] cpu_data_out;
   logic                cpu_write_en;
   logic [Wordsize-1:0] cpu_data_in;
   logic                dma_req;
   logic                dma_gnt;
   logic [Wordsize-1:0] dma_addr;
   logic [Wordsize-1:0] dma_wdata;
   logic                dma_write_en;
   logic                dma_read_en;
   logic [Wordsize-1:0] dma_rdata;
   logic                dma_rvalid;
   logic [Wordsize-1:0] mem_addr;
   logic [Wordsize-1:0] mem_data_out;
   logic                mem_write_en;
   logic [Wordsize-1:0] mem_data_in;

   // Arbiter side.
   modport slave (
      input  enable, cpu_addr, cpu_data_out, cpu_write_en, dma_req, dma_addr, dma_wdata,
             dma_write_en, dma_read_en, mem_data_in,
      output cpu_enable, cpu_data_in, dma_gnt, dma_rdata, dma_rvalid, mem_addr, mem_data_out,
             mem_write_en
   );

   // Environment side: masters and memory.
   modport master (
      output enable, cpu_addr, cpu_data_out, cpu_write_en, dma_req, dma_addr, dma_wdata,
             dma_write_en, dma_read_en, mem_data_in,
      input  cpu_enable, cpu_data_in, dma_gnt, dma_rdata, dma_rvalid, mem_addr, mem_data_out,
             mem_write_en
   );
endinterface

// File: rtl/reflet_bus_arbiter_counter.sv
// Loadable up/down counter; counting down saturates at zero.
module reflet_bus_arbiter_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             up_i,
   input  logic             down_i,
   input  logic [Width-1:0] term_val_i,
   output logic             term_o
);
   logic [Width-1:0] count_d, count_q;

   // Next count: load wins over up, up wins over down.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (up_i) begin
         count_d = count_q + Width'(1);
      end else if (down_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign term_o = (count_q == term_val_i);
endmodule

// File: rtl/reflet_bus_arbiter.sv
// Shares one synchronous memory port between the CPU and a secondary master,
// stalling the CPU while the secondary master holds a bounded tenure.
module reflet_bus_arbiter
   import reflet_bus_arbiter_pkg::*;
#(
   parameter int unsigned MaxBurst = 8,
   parameter int unsigned CpuMin   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   reflet_bus_arbiter_if.slave  bus_io
);
   localparam int unsigned BurstW = cnt_width(MaxBurst);
   localparam int unsigned CoolW  = cnt_width(CpuMin);
   localparam logic [BurstW-1:0] BurstLast = BurstW'(MaxBurst - 1);
   localparam logic [CoolW-1:0]  CoolLoad  = CoolW'(CpuMin);

   arb_state_e state_d, state_q;
   logic       burst_last;
   logic       cool_zero;
   logic       rvalid_d, rvalid_q;

   // Burst counter: cleared on handover, counts each DMA-owned cycle.
   reflet_bus_arbiter_counter #(
      .Width(BurstW)
   ) u_burst (
      .clk       (clk),
      .reset     (reset),
      .load_i    (state_q == StHandover),
      .load_val_i('0),
      .up_i      (state_q == StDmaOwn),
      .down_i    (1'b0),
      .term_val_i(BurstLast),
      .term_o    (burst_last)
   );

   // Cooldown counter: armed on handback, drains while the CPU owns the bus.
   reflet_bus_arbiter_counter #(
      .Width(CoolW)
   ) u_cool (
      .clk       (clk),
      .reset     (reset),
      .load_i    (state_q == StHandback),
      .load_val_i(CoolLoad),
      .up_i      (1'b0),
      .down_i    (state_q == StCpuOwn),
      .term_val_i('0),
      .term_o    (cool_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StCpuOwn;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the DMA tenure ignores the global enable once granted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StCpuOwn: begin
            if (bus_io.dma_req && cool_zero && bus_io.enable) state_d = StHandover;
         end
         StHandover: state_d = StDmaOwn;
         StDmaOwn: begin
            if (!bus_io.dma_req || burst_last) state_d = StHandback;
         end
         StHandback: state_d = StCpuOwn;
         default:    state_d = StCpuOwn;
      endcase
   end

   // Output muxes; handover/handback present the CPU address so its pending
   // read is refetched before it resumes. Reset forces idle values at once.
   always_comb begin
      bus_io.cpu_enable   = 1'b0;
      bus_io.dma_gnt      = 1'b0;
      bus_io.mem_addr     = bus_io.cpu_addr;
      bus_io.mem_data_out = bus_io.cpu_data_out;
      bus_io.mem_write_en = 1'b0;
      unique case (state_q)
         StCpuOwn: begin
            bus_io.cpu_enable   = bus_io.enable;
            bus_io.mem_write_en = bus_io.cpu_write_en & bus_io.enable;
         end
         StDmaOwn: begin
            bus_io.dma_gnt      = 1'b1;
            bus_io.mem_addr     = bus_io.dma_addr;
            bus_io.mem_data_out = bus_io.dma_wdata;
            bus_io.mem_write_en = bus_io.dma_write_en;
         end
         default: ;
      endcase
      if (!reset) begin
         bus_io.cpu_enable   = 1'b0;
         bus_io.dma_gnt      = 1'b0;
         bus_io.mem_addr     = '0;
         bus_io.mem_data_out = '0;
         bus_io.mem_write_en = 1'b0;
      end
   end

   // Read-valid tracks the memory's one-cycle read latency.
   always_comb begin
      rvalid_d = (state_q == StDmaOwn) && bus_io.dma_read_en;
   end

   // Read-valid register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rvalid_d;
      end
   end

   assign bus_io.dma_rvalid  = rvalid_q;
   assign bus_io.cpu_data_in = bus_io.mem_data_in;
   assign bus_io.dma_rdata   = bus_io.mem_data_in;
endmodule
